// File: rtl/ha_serial_seq.sv
// Bit-serial adder: one bit per cycle, LSB first, through two cascaded half adders.
// Fixed latency of WIDTH cycles from start acceptance to the result, then a one-cycle done pulse.
module ha_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Shared 1-bit datapath: operand half adder, then carry-in half adder.
  logic             s1, c1, s_bit, c2, carry_d;
  logic [WIDTH-1:0] work_d;

  assign s1      = a_q[0] ^ b_q[0];
  assign c1      = a_q[0] & b_q[0];
  assign s_bit   = s1 ^ carry_q;
  assign c2      = s1 & carry_q;
  assign carry_d = c1 | c2;
  assign work_d  = {s_bit, work_q[WIDTH-1:1]};

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // A cancel wins over processing the current bit.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              sum_q   <= work_d;
              cout_q  <= carry_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ha_serial_seq.sv
// Scoreboarded bench for ha_serial_seq: the driver queues expected results from an
// arithmetic model, and an independent monitor matches them against done pulses.
module tb_ha_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] a_drv;
  logic [W-1:0] b_drv;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;

  ha_serial_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .a    (a_drv),
    .b    (b_drv),
    .sum  (sum),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int unsigned  at;
  } exp_t;

  exp_t sb[$];

  // Reference: plain (W+1)-bit addition, done expected W cycles after acceptance.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int unsigned acc);
    exp_t       e;
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.at = acc + W;
    return e;
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc >= sb[0].at) begin
        exp_t e;
        e = sb.pop_front();
        check("done_latency", 32'(done), 32'(1));
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
      end else if (done) begin
        check("done_unexpected", 32'(done), 32'(0));
      end
    end
  end

  // Issue one addition; returns at the negedge right after acceptance edge E0.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit with_abort, input bit expect_result);
    @(negedge clk);
    a_drv = x;
    b_drv = y;
    start = 1'b1;
    abort = with_abort;
    if (expect_result) sb.push_back(model(x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    a_drv = W'($urandom);
    b_drv = W'($urandom);
  endtask

  initial begin
    int unsigned acc;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a_drv = '0;
    b_drv = '0;
    #1;
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed 0x5A+0x33 with busy/done timing around E0..E9.
    acc = cyc + 2;
    do_op(8'h5A, 8'h33, 1'b0, 1'b1);
    for (int k = 0; k <= W + 1; k++) begin
      check("busy_window", 32'(busy), 32'(k <= W));
      if (k <= W) @(negedge clk);
    end
    check("sum_5a33", 32'(sum), 32'h8D);

    do_op(8'hFF, 8'h01, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    // start with abort in IDLE is still accepted.
    do_op(8'hFF, 8'hFF, 1'b1, 1'b1);
    repeat (W + 1) @(negedge clk);
    do_op(8'h00, 8'h00, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    do_op(8'h0F, 8'h01, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);

    // start held high: accepted only at E0 and E10.
    @(negedge clk);
    a_drv = 8'h10;
    b_drv = 8'h20;
    start = 1'b1;
    acc   = cyc + 1;
    sb.push_back(model(8'h10, 8'h20, acc));
    sb.push_back(model(8'h10, 8'h20, acc + W + 2));
    repeat (W + 2) @(negedge clk);
    check("held_idle_gap", 32'(busy), 32'(0));
    @(negedge clk);
    start = 1'b0;
    check("held_reaccept", 32'(busy), 32'(1));
    repeat (W + 2) @(negedge clk);

    // Abort mid-run leaves the previous result intact.
    do_op(8'h01, 8'h01, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_sum", 32'(sum), 32'h02);
    check("abort_cout", 32'(cout), 32'(0));
    repeat (W + 2) @(negedge clk);

    // Asynchronous reset mid-run of 0xAA+0x55.
    do_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_sum", 32'(sum), 32'(0));
    check("arst_cout", 32'(cout), 32'(0));
    #1 rst = 1'b0;
    do_op(8'h01, 8'h02, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    check("post_rst_sum", 32'(sum), 32'h03);

    // Randomized operations with random idle gaps, including back-to-back.
    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      repeat (W + $urandom_range(0, 3)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
